cl_pcim_stream_writer: RTL and testbench
========================================

// Module: cl_pcim_stream_writer
// PURPOSE
// - 64b AXI-Stream in -> AXI4 write bursts out on 512b PCIM master (CL -> host memory).
// - Counterpart of the PCIS DMA inbound path: accepts the post-processing 64b stream,
//   packs 8 words per 512b beat, and writes it into a host ring buffer with AW/W/B handling.
// - Sits between the outbound data FIFO and the PCIM AXI4 register slice.
// PARAMETERS
// - BURST_LEN      16   max beats per AW burst (1..64; 64B beats, never crosses 4KB)
// - FIFO_DEPTH     64   512b beat FIFO depth (power of 2, >= 2*BURST_LEN)
// - MAX_OUTSTD     8    max AW issued without B response (1..16)
// - AWID_VAL       0    constant 16b value driven on awid
// PORTS
// - clk_main_a0      in   1    clock
// - rst_main_n       in   1    reset, asynchronous, active-low
// - cfg_enable       in   1    1 = run; 0 = stop issuing new AW (in-flight bursts finish)
// - cfg_base_addr    in   64   ring base, 4KB aligned (bits [11:0] ignored)
// - cfg_ring_beats   in   20   ring size in 64B beats, multiple of BURST_LEN, nonzero
// - s_axis_tvalid/tready in/out 1  input stream handshake
// - s_axis_tdata     in   64   input word
// - s_axis_tlast     in   1    flush: close current beat (partial) and allow short burst
// - cl_sh_pcim_awid/awaddr/awlen/awsize/awvalid  out 16/64/8/3/1; awready in 1
// - cl_sh_pcim_wdata/wstrb/wlast/wvalid  out 512/64/1/1; wready in 1
// - sh_cl_pcim_bid/bresp/bvalid in 16/2/1; bready out 1
// - wr_ptr           out  20   next ring beat index to be written
// - beats_done       out  32   beats acknowledged by OKAY B responses (wraps)
// - err_sticky       out  1    set on bresp!=OKAY (or timeout); cleared only by reset
// BEHAVIOUR
// - Reset (async assert, sync deassert internally, 2 flops): all valids 0, bready 0,
//   tready 0, wr_ptr/beats_done/err_sticky 0, FIFO empty, outstanding count 0.
// - Packer: word k of beat at wdata[64k+63:64k]; k=0..7. Full beat (8 words) or tlast
//   pushes beat + strb into FIFO; partial beat strb = 8*words bytes low, rest 0.
//   tready = !FIFO_full after reset sync; input never dropped.
// - Burst length L = min(FIFO count, BURST_LEN, beats to 4KB boundary, beats to ring end).
//   Issue when count >= BURST_LEN, or flush pending (tlast beat in FIFO) and count >= 1.
// - FSM IDLE -> AW (awvalid=1, awaddr=base+wr_ptr*64, awlen=L-1, awsize=3'b110) ->
//   on awready: DATA (stream L beats, wlast on L-th) -> on last wready: IDLE.
//   AW held stable until awready; W only after AW accepted; one burst in DATA at a time.
// - IDLE->AW also requires cfg_enable=1 and outstanding < MAX_OUTSTD.
// - wr_ptr += L at AW accept; wraps to 0 at cfg_ring_beats (no burst spans the wrap).
// - Outstanding: +1 on AW accept, -1 on B handshake; same-cycle both -> unchanged.
// - bready = 1 whenever outstanding > 0. bresp OKAY: beats_done += that burst's L
//   (L queue depth MAX_OUTSTD, FIFO order). bresp!=OKAY: err_sticky=1, beats_done unchanged.
// - cfg_enable 1->0 mid-DATA: burst completes; no further AW.
// - FIFO full: tready=0; FIFO empty in DATA cannot occur (L <= count at AW).
// - Mid-operation reset: everything discarded; host re-arms ring after reset.
// CONFIGURATION
// - CL_PCIM_WR_TIMEOUT_EN defined: 16b counter per oldest outstanding burst; no B within
//   65535 cycles -> err_sticky=1, burst retired (outstanding-1, beats_done unchanged).
// - Not defined: no timeout, waits indefinitely for B; counter logic absent.
// TESTING
// - 16 words, tlast on 16th, BURST_LEN=16, base 0x1000 -> one AW addr 0x1000 awlen=1,
//   2 beats strb all-ones, wlast on beat 2; B OKAY -> beats_done=2, wr_ptr=2.
// - 3 words + tlast -> AW awlen=0, wstrb=64'h0000_0000_00FF_FFFF, wdata[191:0]=words.
// - cfg_ring_beats=32, stream 40 full beats -> bursts at ptr 0,16, then ptr 0 (wrap),
//   wr_ptr=8 after final flush burst; no burst crosses 4KB or ring end.
// - awready held 0 for 50 cycles -> awaddr/awlen stable, wvalid 0, tready drops at FIFO full.
// - bresp=2'b10 on 2nd burst -> err_sticky=1, beats_done counts 1st burst only.
// - MAX_OUTSTD=2, bvalid withheld -> exactly 2 AW issued, 3rd stalls until one B arrives.

Source files
------------

// File: rtl/cl_pcim_stream_writer.sv
// Packs a 64b AXI-Stream into 512b beats and writes them as AXI4 bursts into a host ring buffer.
// Optional B-response timeout: define CL_PCIM_WR_TIMEOUT_EN.
module cl_pcim_stream_writer #(
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter int          MAX_OUTSTD = 8,
  parameter logic [15:0] AWID_VAL   = 16'h0
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_n,
  input  logic         cfg_enable,
  input  logic [63:0]  cfg_base_addr,
  input  logic [19:0]  cfg_ring_beats,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [63:0]  s_axis_tdata,
  input  logic         s_axis_tlast,
  output logic [15:0]  cl_sh_pcim_awid,
  output logic [63:0]  cl_sh_pcim_awaddr,
  output logic [7:0]   cl_sh_pcim_awlen,
  output logic [2:0]   cl_sh_pcim_awsize,
  output logic         cl_sh_pcim_awvalid,
  input  logic         sh_cl_pcim_awready,
  output logic [511:0] cl_sh_pcim_wdata,
  output logic [63:0]  cl_sh_pcim_wstrb,
  output logic         cl_sh_pcim_wlast,
  output logic         cl_sh_pcim_wvalid,
  input  logic         sh_cl_pcim_wready,
  input  logic [15:0]  sh_cl_pcim_bid,
  input  logic [1:0]   sh_cl_pcim_bresp,
  input  logic         sh_cl_pcim_bvalid,
  output logic         cl_sh_pcim_bready,
  output logic [19:0]  wr_ptr,
  output logic [31:0]  beats_done,
  output logic         err_sticky
);

  // state   | meaning
  // IDLE    | waiting for enough buffered beats (or a flush) and a free outstanding slot
  // AW      | address phase presented, held until awready
  // DATA    | streaming len_q beats from the beat FIFO
  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_DATA} state_t;

  localparam int             FAW      = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0]   FIFO_CAP = (FAW+1)'(FIFO_DEPTH);
  localparam logic [20:0]    BL21     = 21'(BURST_LEN);
  localparam logic [4:0]     MAXO5    = 5'(MAX_OUTSTD);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t       state, state_nxt;
  logic         load_len;
  logic         s_hs, aw_hs, w_hs, b_hs, retire, to_fire;
  logic         push, pop, fifo_full, fifo_empty, issue_ok;
  logic [2:0]   pk_cnt;
  logic [511:0] pk_data, pk_beat;
  logic [63:0]  pk_strb, pk_beat_strb;
  logic [511:0] mem_data [FIFO_DEPTH];
  logic [63:0]  mem_strb [FIFO_DEPTH];
  logic         mem_last [FIFO_DEPTH];
  logic [FAW-1:0] fwp, frp;
  logic [FAW:0] fcnt, flush_cnt;
  logic [20:0]  c_cnt, c_4k, c_ring, len_min, ptr_nxt;
  logic [6:0]   len_calc, len_q, wbeat;
  logic [6:0]   lq [16];
  logic [3:0]   lq_wp, lq_rp;
  logic [4:0]   outstd;
  logic         unused_ok;

  assign unused_ok = ^{sh_cl_pcim_bid, cfg_base_addr[11:0]};

  assign s_axis_tready = rst_n && !fifo_full;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign aw_hs         = cl_sh_pcim_awvalid && sh_cl_pcim_awready;
  assign w_hs          = cl_sh_pcim_wvalid && sh_cl_pcim_wready;
  assign b_hs          = sh_cl_pcim_bvalid && cl_sh_pcim_bready;
  assign retire        = b_hs || to_fire;

  always_comb begin
    pk_beat      = pk_data;
    pk_beat[{pk_cnt, 6'd0} +: 64] = s_axis_tdata;
    pk_beat_strb = pk_strb;
    pk_beat_strb[{pk_cnt, 3'd0} +: 8] = 8'hFF;
  end

  assign push = s_hs && ((pk_cnt == 3'd7) || s_axis_tlast);
  assign pop  = w_hs;

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      pk_cnt  <= '0;
      pk_data <= '0;
      pk_strb <= '0;
    end else if (push) begin
      pk_cnt  <= '0;
      pk_data <= '0;
      pk_strb <= '0;
    end else if (s_hs) begin
      pk_cnt  <= pk_cnt + 3'd1;
      pk_data <= pk_beat;
      pk_strb <= pk_beat_strb;
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (push) begin
      mem_data[fwp] <= pk_beat;
      mem_strb[fwp] <= pk_beat_strb;
      mem_last[fwp] <= s_axis_tlast;
    end
  end

  assign fifo_full  = (fcnt == FIFO_CAP);
  assign fifo_empty = (fcnt == '0);

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      fwp       <= '0;
      frp       <= '0;
      fcnt      <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) fwp <= fwp + 1'b1;
      if (pop)  frp <= frp + 1'b1;
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      case ({push && s_axis_tlast, pop && mem_last[frp]})
        2'b10:   flush_cnt <= flush_cnt + 1'b1;
        2'b01:   flush_cnt <= flush_cnt - 1'b1;
        default: flush_cnt <= flush_cnt;
      endcase
    end
  end

  // Burst never runs past the buffered data, a 4KB page, or the ring end.
  always_comb begin
    c_cnt   = 21'(fcnt);
    c_4k    = 21'd64 - {15'd0, wr_ptr[5:0]};
    c_ring  = {1'b0, cfg_ring_beats} - {1'b0, wr_ptr};
    len_min = c_cnt;
    if (BL21 < len_min)   len_min = BL21;
    if (c_4k < len_min)   len_min = c_4k;
    if (c_ring < len_min) len_min = c_ring;
    len_calc = 7'(len_min);
    issue_ok = cfg_enable && (outstd < MAXO5) && (len_min != 21'd0) &&
               ((c_cnt >= BL21) || (flush_cnt != '0));
  end

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_len  = 1'b0;
    case (state)
      ST_IDLE: if (issue_ok) begin
        state_nxt = ST_AW;
        load_len  = 1'b1;
      end
      ST_AW:   if (sh_cl_pcim_awready) state_nxt = ST_DATA;
      ST_DATA: if (w_hs && cl_sh_pcim_wlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cl_sh_pcim_awid    = AWID_VAL;
  assign cl_sh_pcim_awvalid = (state == ST_AW);
  assign cl_sh_pcim_awaddr  = {cfg_base_addr[63:12], 12'd0} + {38'd0, wr_ptr, 6'd0};
  assign cl_sh_pcim_awlen   = {1'b0, len_q} - 8'd1;
  assign cl_sh_pcim_awsize  = 3'b110;
  assign cl_sh_pcim_wvalid  = (state == ST_DATA) && !fifo_empty;
  assign cl_sh_pcim_wdata   = mem_data[frp];
  assign cl_sh_pcim_wstrb   = mem_strb[frp];
  assign cl_sh_pcim_wlast   = (wbeat == (len_q - 7'd1));
  assign cl_sh_pcim_bready  = (outstd != 5'd0);

  assign ptr_nxt = {1'b0, wr_ptr} + 21'(len_q);

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      wbeat  <= '0;
      wr_ptr <= '0;
    end else begin
      if (load_len) len_q <= len_calc;
      if (aw_hs) begin
        wbeat  <= '0;
        wr_ptr <= (ptr_nxt >= {1'b0, cfg_ring_beats}) ? 20'd0 : ptr_nxt[19:0];
      end else if (w_hs) begin
        wbeat  <= wbeat + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (aw_hs) lq[lq_wp] <= len_q;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      lq_wp      <= '0;
      lq_rp      <= '0;
      outstd     <= '0;
      beats_done <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (aw_hs)  lq_wp <= lq_wp + 4'd1;
      if (retire) lq_rp <= lq_rp + 4'd1;
      case ({aw_hs, retire})
        2'b10:   outstd <= outstd + 5'd1;
        2'b01:   outstd <= outstd - 5'd1;
        default: outstd <= outstd;
      endcase
      if (b_hs && (sh_cl_pcim_bresp == 2'b00)) beats_done <= beats_done + {25'd0, lq[lq_rp]};
      if ((b_hs && (sh_cl_pcim_bresp != 2'b00)) || to_fire) err_sticky <= 1'b1;
    end
  end

`ifdef CL_PCIM_WR_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Reloads whenever the oldest burst changes; terminal count retires it.
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n)                                  to_cnt <= 16'hFFFE;
    else if ((outstd == 5'd0) || retire)         to_cnt <= 16'hFFFE;
    else                                         to_cnt <= to_cnt - 16'd1;
  end
  assign to_fire = (outstd != 5'd0) && (to_cnt == 16'd0) && !b_hs;
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_cl_pcim_stream_writer.sv
// Directed bench for cl_pcim_stream_writer: packing, burst sizing, ring wrap, AW stall, error and outstanding limit.
module tb_cl_pcim_stream_writer;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n  = 1'b0;
  logic         cfg_enable;
  logic [63:0]  cfg_base_addr;
  logic [19:0]  cfg_ring_beats;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [63:0]  s_axis_tdata;
  logic [15:0]  cl_sh_pcim_awid;
  logic [63:0]  cl_sh_pcim_awaddr;
  logic [7:0]   cl_sh_pcim_awlen;
  logic [2:0]   cl_sh_pcim_awsize;
  logic         cl_sh_pcim_awvalid, sh_cl_pcim_awready;
  logic [511:0] cl_sh_pcim_wdata;
  logic [63:0]  cl_sh_pcim_wstrb;
  logic         cl_sh_pcim_wlast, cl_sh_pcim_wvalid, sh_cl_pcim_wready;
  logic [15:0]  sh_cl_pcim_bid;
  logic [1:0]   sh_cl_pcim_bresp;
  logic         sh_cl_pcim_bvalid, cl_sh_pcim_bready;
  logic [19:0]  wr_ptr;
  logic [31:0]  beats_done;
  logic         err_sticky;

  always #5 clk_main_a0 = ~clk_main_a0;

  cl_pcim_stream_writer #(
    .BURST_LEN(16), .FIFO_DEPTH(64), .MAX_OUTSTD(2), .AWID_VAL(16'h0)
  ) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr), .cfg_ring_beats(cfg_ring_beats),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .cl_sh_pcim_awid(cl_sh_pcim_awid), .cl_sh_pcim_awaddr(cl_sh_pcim_awaddr),
    .cl_sh_pcim_awlen(cl_sh_pcim_awlen), .cl_sh_pcim_awsize(cl_sh_pcim_awsize),
    .cl_sh_pcim_awvalid(cl_sh_pcim_awvalid), .sh_cl_pcim_awready(sh_cl_pcim_awready),
    .cl_sh_pcim_wdata(cl_sh_pcim_wdata), .cl_sh_pcim_wstrb(cl_sh_pcim_wstrb),
    .cl_sh_pcim_wlast(cl_sh_pcim_wlast), .cl_sh_pcim_wvalid(cl_sh_pcim_wvalid),
    .sh_cl_pcim_wready(sh_cl_pcim_wready),
    .sh_cl_pcim_bid(sh_cl_pcim_bid), .sh_cl_pcim_bresp(sh_cl_pcim_bresp),
    .sh_cl_pcim_bvalid(sh_cl_pcim_bvalid), .cl_sh_pcim_bready(cl_sh_pcim_bready),
    .wr_ptr(wr_ptr), .beats_done(beats_done), .err_sticky(err_sticky)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host-side logs, sampled at negedge (the handshake completes on the next posedge).
  logic [63:0]  aw_addr_q [$];
  logic [7:0]   aw_len_q  [$];
  int           aw_bn_q   [$];
  logic [511:0] w_data_q  [$];
  logic [63:0]  w_strb_q  [$];
  logic         w_last_q  [$];

  int   pend    = 0;
  int   b_cnt   = 0;
  int   err_idx = -1;
  logic b_hold  = 1'b0;
  logic wl_s, b_s;

  always @(negedge clk_main_a0) begin
    if (rst_main_n && cl_sh_pcim_awvalid && sh_cl_pcim_awready) begin
      aw_addr_q.push_back(cl_sh_pcim_awaddr);
      aw_len_q.push_back(cl_sh_pcim_awlen);
      aw_bn_q.push_back(b_cnt);
    end
    if (rst_main_n && cl_sh_pcim_wvalid && sh_cl_pcim_wready) begin
      w_data_q.push_back(cl_sh_pcim_wdata);
      w_strb_q.push_back(cl_sh_pcim_wstrb);
      w_last_q.push_back(cl_sh_pcim_wlast);
    end
  end

  // In-order B responder: one response per completed W burst.
  initial begin
    sh_cl_pcim_bvalid = 1'b0;
    sh_cl_pcim_bresp  = 2'b00;
    sh_cl_pcim_bid    = 16'h0;
    forever begin
      @(negedge clk_main_a0);
      wl_s = cl_sh_pcim_wvalid && sh_cl_pcim_wready && cl_sh_pcim_wlast;
      b_s  = sh_cl_pcim_bvalid && cl_sh_pcim_bready;
      @(posedge clk_main_a0);
      #1;
      if (!rst_main_n) begin
        pend  = 0;
        b_cnt = 0;
      end else begin
        if (wl_s) pend++;
        if (b_s) begin
          pend--;
          b_cnt++;
        end
      end
      sh_cl_pcim_bvalid = (pend > 0) && !b_hold;
      sh_cl_pcim_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic apply_reset(input logic [63:0] base, input logic [19:0] ring);
    rst_main_n         = 1'b0;
    s_axis_tvalid      = 1'b0;
    s_axis_tlast       = 1'b0;
    s_axis_tdata       = '0;
    sh_cl_pcim_awready = 1'b1;
    sh_cl_pcim_wready  = 1'b1;
    b_hold             = 1'b0;
    err_idx            = -1;
    cfg_enable         = 1'b1;
    cfg_base_addr      = base;
    cfg_ring_beats     = ring;
    repeat (3) @(posedge clk_main_a0);
    #1;
    chk_eq("reset_state",
           {cl_sh_pcim_awvalid, cl_sh_pcim_wvalid, cl_sh_pcim_bready, s_axis_tready,
            err_sticky, wr_ptr, beats_done}, '0);
    aw_addr_q.delete(); aw_len_q.delete(); aw_bn_q.delete();
    w_data_q.delete();  w_strb_q.delete(); w_last_q.delete();
    rst_main_n = 1'b1;
    repeat (4) @(posedge clk_main_a0);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic l, input int max_wait, output logic ok);
    int   n;
    logic hs;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < max_wait) begin
      @(negedge clk_main_a0);
      hs = s_axis_tready;
      @(posedge clk_main_a0);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    ok = hs;
  endtask

  function automatic logic [63:0] word_of(input logic [15:0] tag, input int i);
    return {tag, 16'h0, 32'(i)};
  endfunction

  task automatic send_stream(input logic [15:0] tag, input int nwords, input logic last_at_end);
    int   acc;
    logic ok;
    acc = 0;
    for (int i = 0; i < nwords; i++) begin
      send_word(word_of(tag, i), last_at_end && (i == nwords - 1), 200, ok);
      if (ok) acc++;
    end
    chk_eq("words_accepted", acc, nwords);
  endtask

  task automatic wait_beats(input string tag, input logic [31:0] target, input int budget);
    int n;
    n = 0;
    while (beats_done !== target && n < budget) begin
      @(posedge clk_main_a0);
      #1;
      n++;
    end
    repeat (20) @(posedge clk_main_a0);
    #1;
    chk_eq(tag, beats_done, target);
  endtask

  logic [511:0] exp_data;
  logic [63:0]  exp_addr [4];
  logic [7:0]   exp_len  [3];
  logic         ok_w, stable;
  int           accepted, n;

  initial begin
    // Reset state and release
    apply_reset(64'h1000, 20'd1024);
    chk_eq("tready_after_reset", s_axis_tready, 1'b1);

    // 16 words, tlast on the 16th -> one 2-beat burst
    send_stream(16'hA001, 16, 1'b1);
    wait_beats("t1_beats_done", 32'd2, 500);
    chk_eq("t1_aw_count", aw_addr_q.size(), 1);
    chk_eq("t1_awaddr", aw_addr_q[0], 64'h1000);
    chk_eq("t1_awlen", aw_len_q[0], 8'd1);
    chk_eq("t1_w_count", w_data_q.size(), 2);
    chk_eq("t1_strb0", w_strb_q[0], {64{1'b1}});
    chk_eq("t1_strb1", w_strb_q[1], {64{1'b1}});
    chk_eq("t1_wlast", {w_last_q[0], w_last_q[1]}, 2'b01);
    for (int k = 0; k < 8; k++) exp_data[64*k +: 64] = word_of(16'hA001, k);
    chk_eq("t1_wdata0", w_data_q[0], exp_data);
    for (int k = 0; k < 8; k++) exp_data[64*k +: 64] = word_of(16'hA001, k + 8);
    chk_eq("t1_wdata1", w_data_q[1], exp_data);
    chk_eq("t1_wr_ptr", wr_ptr, 20'd2);

    // 3 words with tlast -> partial single beat
    apply_reset(64'h5000, 20'd1024);
    send_stream(16'hB002, 3, 1'b1);
    wait_beats("t2_beats_done", 32'd1, 500);
    chk_eq("t2_aw_count", aw_addr_q.size(), 1);
    chk_eq("t2_awaddr", aw_addr_q[0], 64'h5000);
    chk_eq("t2_awlen", aw_len_q[0], 8'd0);
    chk_eq("t2_wstrb", w_strb_q[0], 64'h0000_0000_00FF_FFFF);
    exp_data = '0;
    for (int k = 0; k < 3; k++) exp_data[64*k +: 64] = word_of(16'hB002, k);
    chk_eq("t2_wdata", w_data_q[0], exp_data);
    chk_eq("t2_wlast", w_last_q[0], 1'b1);
    chk_eq("t2_wr_ptr", wr_ptr, 20'd1);

    // 40 full beats into a 32-beat ring: bursts at 0, 16, then wrap to 0 (8-beat flush)
    apply_reset(64'h2000, 20'd32);
    send_stream(16'hC003, 320, 1'b1);
    wait_beats("t3_beats_done", 32'd40, 3000);
    chk_eq("t3_aw_count", aw_addr_q.size(), 3);
    exp_addr[0] = 64'h2000; exp_addr[1] = 64'h2400; exp_addr[2] = 64'h2000;
    exp_len[0]  = 8'd15;    exp_len[1]  = 8'd15;    exp_len[2]  = 8'd7;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("t3_awaddr%0d", i), aw_addr_q[i], exp_addr[i]);
      chk_eq($sformatf("t3_awlen%0d", i), aw_len_q[i], exp_len[i]);
    end
    chk_eq("t3_w_count", w_data_q.size(), 40);
    chk_eq("t3_final_wlast", w_last_q[39], 1'b1);
    chk_eq("t3_wr_ptr", wr_ptr, 20'd8);

    // awready held low: AW stable, no W, FIFO fills to 64 beats, tready drops
    apply_reset(64'h1000, 20'd1024);
    sh_cl_pcim_awready = 1'b0;
    accepted = 0;
    ok_w     = 1'b1;
    for (int i = 0; i < 600 && ok_w; i++) begin
      send_word(word_of(16'hD004, i), 1'b0, 20, ok_w);
      if (ok_w) accepted++;
    end
    chk_eq("t4_words_until_full", accepted, 512);
    chk_eq("t4_tready_low", s_axis_tready, 1'b0);
    chk_eq("t4_awsize", cl_sh_pcim_awsize, 3'b110);
    chk_eq("t4_awid", cl_sh_pcim_awid, 16'h0);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cl_sh_pcim_awvalid !== 1'b1 || cl_sh_pcim_awaddr !== 64'h1000 ||
          cl_sh_pcim_awlen !== 8'd15 || cl_sh_pcim_wvalid !== 1'b0) stable = 1'b0;
      @(posedge clk_main_a0);
      #1;
    end
    chk_eq("t4_aw_stable_no_w", stable, 1'b1);
    sh_cl_pcim_awready = 1'b1;
    wait_beats("t4_beats_done", 32'd64, 2000);
    chk_eq("t4_aw_count", aw_addr_q.size(), 4);
    exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1400; exp_addr[2] = 64'h1800; exp_addr[3] = 64'h1C00;
    for (int i = 0; i < 4; i++) chk_eq($sformatf("t4_awaddr%0d", i), aw_addr_q[i], exp_addr[i]);
    chk_eq("t4_wr_ptr", wr_ptr, 20'd64);

    // Error response on second burst
    apply_reset(64'h3000, 20'd1024);
    err_idx = 1;
    send_stream(16'hE005, 16, 1'b1);
    wait_beats("t5_beats_first", 32'd2, 500);
    chk_eq("t5_err_clear", err_sticky, 1'b0);
    send_stream(16'hE006, 8, 1'b1);
    n = 0;
    while (err_sticky !== 1'b1 && n < 500) begin
      @(posedge clk_main_a0);
      #1;
      n++;
    end
    repeat (10) @(posedge clk_main_a0);
    #1;
    chk_eq("t5_err_sticky", err_sticky, 1'b1);
    chk_eq("t5_beats_done", beats_done, 32'd2);
    chk_eq("t5_wr_ptr", wr_ptr, 20'd3);
    chk_eq("t5_bready_idle", cl_sh_pcim_bready, 1'b0);

    // Outstanding limit of 2 with B withheld
    apply_reset(64'h1000, 20'd1024);
    b_hold = 1'b1;
    send_stream(16'hF007, 384, 1'b0);
    repeat (50) @(posedge clk_main_a0);
    #1;
    chk_eq("t6_aw_count_held", aw_addr_q.size(), 2);
    chk_eq("t6_awvalid_held", cl_sh_pcim_awvalid, 1'b0);
    chk_eq("t6_bready_held", cl_sh_pcim_bready, 1'b1);
    b_hold = 1'b0;
    wait_beats("t6_beats_done", 32'd48, 3000);
    chk_eq("t6_aw_count", aw_addr_q.size(), 3);
    chk_eq("t6_aw3_after_b", (aw_bn_q.size() >= 3) && (aw_bn_q[2] >= 1), 1'b1);
    chk_eq("t6_wr_ptr", wr_ptr, 20'd48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
